// File: rtl/rob_ctrl.sv
// ----------------------------------------------------------------------------
// rob_ctrl
//   Pointer and sequencing controller for the multi-bank reorder buffer.
//   Owns the head/tail row pointers and the row occupancy count. It grants
//   dispatch of one full row per cycle and issues in-order per-lane commit
//   strobes for the head row. A branch kill rolls the tail back, and an
//   exception flushes the whole buffer.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_dis_req         dispatch request for one full row
//   o_dis_ack         dispatch accepted this cycle
//   o_dis_tag         row allocated to the accepted dispatch (= tail)
//   i_row_done        per-lane completion of the head-row entries
//   o_com_en          per-lane commit strobe for the head row
//   o_head_adv        head row fully retired this cycle
//   i_kill            branch mispredict
//   i_kill_row        row holding the mispredicted branch (kept)
//   i_exc             exception at head; flush everything
//   o_flush           one-cycle flush pulse
//   o_head, o_tail    row pointers
//   o_count           occupied rows, 0..SIZE
//   o_full, o_empty   occupancy decodes
// ----------------------------------------------------------------------------
module rob_ctrl #(
    parameter int WIDTH_BANK = 3,
    parameter int NBANK      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dis_req,
    output logic                  o_dis_ack,
    output logic [WIDTH_BANK-1:0] o_dis_tag,
    input  logic [NBANK-1:0]      i_row_done,
    output logic [NBANK-1:0]      o_com_en,
    output logic                  o_head_adv,
    input  logic                  i_kill,
    input  logic [WIDTH_BANK-1:0] i_kill_row,
    input  logic                  i_exc,
    output logic                  o_flush,
    output logic [WIDTH_BANK-1:0] o_head,
    output logic [WIDTH_BANK-1:0] o_tail,
    output logic [WIDTH_BANK:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int CW   = WIDTH_BANK + 1;
    localparam int SIZE = 2 ** WIDTH_BANK;

    typedef enum logic [1:0] {
        S_RUN,
        S_KILL,
        S_FLUSH
    } state_t;

    logic [WIDTH_BANK-1:0] r_head, r_tail;
    logic [CW-1:0]         r_count;
    logic [NBANK-1:0]      r_done_mask;
    state_t                r_state;

    logic [WIDTH_BANK-1:0] w_head_nx, w_tail_nx;
    logic [CW-1:0]         w_count_nx;
    logic [NBANK-1:0]      w_done_mask_nx;
    state_t                w_state_nx;

    logic                  w_run;
    logic                  w_full;
    logic                  w_ack;
    logic                  w_com_ok;
    logic                  w_pref;
    logic [NBANK-1:0]      w_com_en;
    logic                  w_head_adv;
    logic [WIDTH_BANK-1:0] w_kill_dist;
    logic                  w_kill_ok;

    assign w_run  = (r_state == S_RUN);
    assign w_full = (r_count == CW'(SIZE));

    // Full is judged on the registered count, so a same-cycle retire never
    // opens a slot for dispatch.
    assign w_ack    = i_dis_req & w_run & ~w_full & ~i_kill & ~i_exc;
    assign w_com_ok = w_run & (r_count != '0) & ~i_exc;

    // A lane may commit only once every lane at or below it is complete or
    // already committed, which keeps commits strictly in lane order.
    always_comb begin
        w_pref   = 1'b1;
        w_com_en = '0;
        for (int unsigned k = 0; k < NBANK; k++) begin
            w_pref      = w_pref & (i_row_done[k] | r_done_mask[k]);
            w_com_en[k] = w_com_ok & ~r_done_mask[k] & w_pref;
        end
    end

    assign w_head_adv = w_com_ok & ((r_done_mask | w_com_en) == '1);

    // Distance from head to the killed row; the kill is real only when that
    // row is currently occupied.
    assign w_kill_dist = i_kill_row - r_head;
    assign w_kill_ok   = i_kill & w_run & ~i_exc & ({1'b0, w_kill_dist} < r_count);

    always_comb begin
        w_head_nx      = r_head;
        w_tail_nx      = r_tail;
        w_count_nx     = r_count;
        w_done_mask_nx = r_done_mask;
        w_state_nx     = r_state;

        if (i_exc) begin
            w_head_nx      = '0;
            w_tail_nx      = '0;
            w_count_nx     = '0;
            w_done_mask_nx = '0;
            w_state_nx     = S_FLUSH;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_head_adv) begin
                        w_head_nx      = r_head + 1'b1;
                        w_done_mask_nx = '0;
                    end else begin
                        w_done_mask_nx = r_done_mask | w_com_en;
                    end

                    if (w_kill_ok) begin
                        // Rows up to and including the killed row survive,
                        // minus the head row if it retires on this same edge.
                        w_tail_nx  = i_kill_row + 1'b1;
                        w_count_nx = CW'(w_kill_dist) + CW'(1) - CW'(w_head_adv);
                        w_state_nx = S_KILL;
                    end else begin
                        if (w_ack) begin
                            w_tail_nx = r_tail + 1'b1;
                        end
                        w_count_nx = r_count + CW'(w_ack) - CW'(w_head_adv);
                    end
                end
                S_KILL:  w_state_nx = S_RUN;
                S_FLUSH: w_state_nx = S_RUN;
                default: w_state_nx = S_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_done_mask <= '0;
            r_state     <= S_RUN;
        end else begin
            r_head      <= w_head_nx;
            r_tail      <= w_tail_nx;
            r_count     <= w_count_nx;
            r_done_mask <= w_done_mask_nx;
            r_state     <= w_state_nx;
        end
    end

    assign o_dis_ack  = w_ack;
    assign o_dis_tag  = r_tail;
    assign o_com_en   = w_com_en;
    assign o_head_adv = w_head_adv;
    assign o_flush    = (r_state == S_FLUSH);
    assign o_head     = r_head;
    assign o_tail     = r_tail;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = (r_count == '0);

endmodule

// File: tb/tb_rob_ctrl.sv
module tb_rob_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_dis_req;
    logic       o_dis_ack;
    logic [2:0] o_dis_tag;
    logic [3:0] i_row_done;
    logic [3:0] o_com_en;
    logic       o_head_adv;
    logic       i_kill;
    logic [2:0] i_kill_row;
    logic       i_exc;
    logic       o_flush;
    logic [2:0] o_head;
    logic [2:0] o_tail;
    logic [3:0] o_count;
    logic       o_full;
    logic       o_empty;

    int n_checks = 0;
    int n_errors = 0;

    rob_ctrl #(.WIDTH_BANK(3), .NBANK(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_dis_req  (i_dis_req),
        .o_dis_ack  (o_dis_ack),
        .o_dis_tag  (o_dis_tag),
        .i_row_done (i_row_done),
        .o_com_en   (o_com_en),
        .o_head_adv (o_head_adv),
        .i_kill     (i_kill),
        .i_kill_row (i_kill_row),
        .i_exc      (i_exc),
        .o_flush    (o_flush),
        .o_head     (o_head),
        .o_tail     (o_tail),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns later, well away from the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dis_req  = 1'b0;
        i_row_done = 4'h0;
        i_kill     = 1'b0;
        i_kill_row = 3'd0;
        i_exc      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic dispatch_rows(input int n);
        i_dis_req = 1'b1;
        for (int i = 0; i < n; i++) step();
        i_dis_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (o_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got %b exp 1", o_empty); end
        n_checks++; if (o_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", o_full); end
        n_checks++; if (o_count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", o_count); end
        n_checks++; if ({o_head, o_tail} !== 6'd0) begin n_errors++; $display("FAIL reset_ptrs got h%0d t%0d exp 0 0", o_head, o_tail); end
        n_checks++; if ({o_flush, o_dis_ack, o_head_adv, o_com_en} !== 7'd0) begin n_errors++; $display("FAIL reset_strobes got %b exp 0", {o_flush, o_dis_ack, o_head_adv, o_com_en}); end
    endtask

    task automatic test_fill();
        i_dis_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (i < 8) begin
                n_checks++; if (o_dis_ack !== 1'b1 || o_dis_tag !== 3'(i)) begin n_errors++; $display("FAIL fill_ack%0d got ack %b tag %0d exp 1 %0d", i, o_dis_ack, o_dis_tag, i); end
            end else begin
                n_checks++; if (o_dis_ack !== 1'b0 || o_full !== 1'b1) begin n_errors++; $display("FAIL fill_full got ack %b full %b exp 0 1", o_dis_ack, o_full); end
                n_checks++; if (o_count !== 4'd8) begin n_errors++; $display("FAIL fill_count got %0d exp 8", o_count); end
            end
            step();
        end
        i_dis_req = 1'b0;
    endtask

    task automatic test_full_retire();
        // Buffer is full with head=tail=0.
        i_row_done = 4'hF;
        i_dis_req  = 1'b1;
        #1;
        n_checks++; if (o_head_adv !== 1'b1 || o_dis_ack !== 1'b0 || o_com_en !== 4'hF) begin n_errors++; $display("FAIL fullret_same got adv %b ack %b en %b exp 1 0 1111", o_head_adv, o_dis_ack, o_com_en); end
        step();
        i_row_done = 4'h0;
        #1;
        n_checks++; if (o_dis_ack !== 1'b1 || o_dis_tag !== 3'd0 || o_count !== 4'd7) begin n_errors++; $display("FAIL fullret_next got ack %b tag %0d cnt %0d exp 1 0 7", o_dis_ack, o_dis_tag, o_count); end
        step();
        i_dis_req = 1'b0;
        n_checks++; if (o_count !== 4'd8 || o_head !== 3'd1 || o_tail !== 3'd1) begin n_errors++; $display("FAIL fullret_refill got cnt %0d h%0d t%0d exp 8 1 1", o_count, o_head, o_tail); end
    endtask

    task automatic test_commit_order();
        do_reset();
        dispatch_rows(3);
        i_row_done = 4'b1011;
        #1;
        n_checks++; if (o_com_en !== 4'b0011 || o_head_adv !== 1'b0) begin n_errors++; $display("FAIL commit_part got en %b adv %b exp 0011 0", o_com_en, o_head_adv); end
        step();
        i_row_done = 4'b1111;
        #1;
        n_checks++; if (o_com_en !== 4'b1100 || o_head_adv !== 1'b1) begin n_errors++; $display("FAIL commit_rest got en %b adv %b exp 1100 1", o_com_en, o_head_adv); end
        step();
        i_row_done = 4'h0;
        n_checks++; if (o_head !== 3'd1 || o_count !== 4'd2) begin n_errors++; $display("FAIL commit_head got h%0d cnt %0d exp 1 2", o_head, o_count); end
    endtask

    task automatic test_back_to_back();
        // 2 rows held; one dispatch and one retire on the same edge.
        i_dis_req  = 1'b1;
        i_row_done = 4'hF;
        #1;
        n_checks++; if (o_dis_ack !== 1'b1 || o_head_adv !== 1'b1) begin n_errors++; $display("FAIL b2b_strobes got ack %b adv %b exp 1 1", o_dis_ack, o_head_adv); end
        step();
        idle_inputs();
        n_checks++; if (o_count !== 4'd2 || o_head !== 3'd2 || o_tail !== 3'd4) begin n_errors++; $display("FAIL b2b_state got cnt %0d h%0d t%0d exp 2 2 4", o_count, o_head, o_tail); end
    endtask

    task automatic test_kill();
        do_reset();
        dispatch_rows(6);
        i_row_done = 4'hF;
        for (int i = 0; i < 6; i++) step();
        i_row_done = 4'h0;
        dispatch_rows(5);
        n_checks++; if (o_head !== 3'd6 || o_tail !== 3'd3 || o_count !== 4'd5) begin n_errors++; $display("FAIL kill_setup got h%0d t%0d cnt %0d exp 6 3 5", o_head, o_tail, o_count); end
        i_kill     = 1'b1;
        i_kill_row = 3'd7;
        i_dis_req  = 1'b1;
        #1;
        n_checks++; if (o_dis_ack !== 1'b0) begin n_errors++; $display("FAIL kill_ack got %b exp 0", o_dis_ack); end
        step();
        i_kill     = 1'b0;
        i_row_done = 4'hF;
        n_checks++; if (o_tail !== 3'd0 || o_count !== 4'd2 || o_head !== 3'd6) begin n_errors++; $display("FAIL kill_state got h%0d t%0d cnt %0d exp 6 0 2", o_head, o_tail, o_count); end
        n_checks++; if (o_dis_ack !== 1'b0 || o_com_en !== 4'h0) begin n_errors++; $display("FAIL kill_stall got ack %b en %b exp 0 0000", o_dis_ack, o_com_en); end
        step();
        i_row_done = 4'h0;
        #1;
        n_checks++; if (o_dis_ack !== 1'b1 || o_dis_tag !== 3'd0) begin n_errors++; $display("FAIL kill_resume got ack %b tag %0d exp 1 0", o_dis_ack, o_dis_tag); end
        i_dis_req = 1'b0;
        step();
        // Row 4 lies outside the occupied range 6..7, so this kill is ignored.
        i_kill     = 1'b1;
        i_kill_row = 3'd4;
        step();
        i_kill    = 1'b0;
        i_dis_req = 1'b1;
        #1;
        n_checks++; if (o_tail !== 3'd0 || o_count !== 4'd2 || o_dis_ack !== 1'b1) begin n_errors++; $display("FAIL kill_invalid got t%0d cnt %0d ack %b exp 0 2 1", o_tail, o_count, o_dis_ack); end
        i_dis_req = 1'b0;
        step();
    endtask

    task automatic test_exception();
        do_reset();
        dispatch_rows(5);
        i_exc      = 1'b1;
        i_kill     = 1'b1;
        i_kill_row = 3'd2;
        i_row_done = 4'hF;
        i_dis_req  = 1'b1;
        #1;
        n_checks++; if (o_dis_ack !== 1'b0 || o_com_en !== 4'h0 || o_head_adv !== 1'b0) begin n_errors++; $display("FAIL exc_cycle got ack %b en %b adv %b exp 0 0000 0", o_dis_ack, o_com_en, o_head_adv); end
        step();
        i_exc  = 1'b0;
        i_kill = 1'b0;
        #1;
        n_checks++; if ({o_head, o_tail} !== 6'd0 || o_count !== 4'd0 || o_flush !== 1'b1) begin n_errors++; $display("FAIL exc_flush got h%0d t%0d cnt %0d fl %b exp 0 0 0 1", o_head, o_tail, o_count, o_flush); end
        n_checks++; if (o_dis_ack !== 1'b0 || o_com_en !== 4'h0) begin n_errors++; $display("FAIL exc_quiet got ack %b en %b exp 0 0000", o_dis_ack, o_com_en); end
        step();
        n_checks++; if (o_flush !== 1'b0 || o_dis_ack !== 1'b1) begin n_errors++; $display("FAIL exc_run got fl %b ack %b exp 0 1", o_flush, o_dis_ack); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_in_kill();
        do_reset();
        dispatch_rows(3);
        i_kill     = 1'b1;
        i_kill_row = 3'd0;
        step();
        i_kill = 1'b0;
        i_rst  = 1'b1;
        step();
        i_rst     = 1'b0;
        i_dis_req = 1'b1;
        #1;
        n_checks++; if ({o_head, o_tail} !== 6'd0 || o_count !== 4'd0 || o_flush !== 1'b0) begin n_errors++; $display("FAIL rstkill_state got h%0d t%0d cnt %0d fl %b exp 0 0 0 0", o_head, o_tail, o_count, o_flush); end
        n_checks++; if (o_dis_ack !== 1'b1) begin n_errors++; $display("FAIL rstkill_run got ack %b exp 1", o_dis_ack); end
        step();
        i_dis_req = 1'b0;
        n_checks++; if (o_flush !== 1'b0 || o_count !== 4'd1) begin n_errors++; $display("FAIL rstkill_after got fl %b cnt %0d exp 0 1", o_flush, o_count); end
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_full_retire();
        test_commit_order();
        test_back_to_back();
        test_kill();
        test_exception();
        test_reset_in_kill();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
